// File: rtl/image_bank_scheduler_pkg.sv
// Shared constants, command codes and FSM state types for the image bank scheduler.
package img_sched_pkg;

    localparam int IMG_BYTES = 784;

    localparam logic [7:0] CMD_LOAD = 8'h67;  // 'g'
    localparam logic [7:0] CMD_RUN  = 8'h64;  // 'd'

    typedef enum logic {L_IDLE, L_RECV} loader_state_t;

    typedef enum logic [1:0] {R_IDLE, R_START, R_WAIT, R_DONE} runner_state_t;

endpackage

// File: rtl/image_bank_scheduler_frame_loader.sv
// UART frame loader: decodes idle-state commands, writes one frame into the
// current fill bank and aborts a frame that stalls mid-transfer.
module frame_loader #(
    parameter int IMG_BYTES      = img_sched_pkg::IMG_BYTES,
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 10_800_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic [1:0]        full,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              done_bank,
    output logic              load_reject,
    output logic              run_req,
    output logic              err_timeout,
    output logic              busy
);
    import img_sched_pkg::*;

    localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);

    loader_state_t     state;
    logic [ADDR_W-1:0] cnt;
    logic [IDLE_W-1:0] idle;
    logic              fill_bank;
    logic              is_load;

    // Command decode only applies in L_IDLE; inside a frame every byte is data.
    assign is_load     = (state == L_IDLE) && rx_valid && (rx_byte == CMD_LOAD);
    assign run_req     = (state == L_IDLE) && rx_valid && (rx_byte == CMD_RUN);
    assign load_reject = is_load && full[fill_bank];
    assign frame_done  = (state == L_RECV) && rx_valid && (cnt == LAST_ADDR);
    assign done_bank   = fill_bank;
    assign busy        = (state != L_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= L_IDLE;
            cnt         <= '0;
            idle        <= '0;
            fill_bank   <= 1'b0;
            wr_en       <= 1'b0;
            wr_bank     <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            err_timeout <= 1'b0;
        end else begin
            // NOTE: strobes default low here so each branch only states when they pulse.
            wr_en       <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                L_IDLE: begin
                    if (is_load && !full[fill_bank]) begin
                        state <= L_RECV;
                        cnt   <= '0;
                        idle  <= '0;
                    end
                end
                L_RECV: begin
                    if (rx_valid) begin
                        wr_en   <= 1'b1;
                        wr_bank <= fill_bank;
                        wr_addr <= cnt;
                        wr_data <= rx_byte;
                        idle    <= '0;
                        if (cnt == LAST_ADDR) begin
                            fill_bank <= ~fill_bank;
                            cnt       <= '0;
                            state     <= L_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (idle == IDLE_MAX) begin
                        // Abort leaves fill_bank alone so the retry rewrites the same bank.
                        err_timeout <= 1'b1;
                        state       <= L_IDLE;
                    end else begin
                        idle <= idle + 1'b1;
                    end
                end
                default: state <= L_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/image_bank_scheduler.sv
// Ping-pong image bank scheduler: UART fills one bank while the CNN classifies
// the other; the LCD follows the most recently completed bank.
module image_bank_scheduler #(
    parameter int IMG_BYTES      = img_sched_pkg::IMG_BYTES,
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 10_800_000,
    parameter int CNN_RST_CYCLES = 2,
    parameter int AUTO_RUN       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cnn_rst,
    output logic              cnn_bank,
    input  logic              cnn_finish,
    input  logic [3:0]        cnn_result,
    output logic              lcd_bank,
    output logic [3:0]        result,
    output logic              result_valid,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_cmd
);
    import img_sched_pkg::*;

    localparam int               RST_W    = $clog2(CNN_RST_CYCLES + 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(CNN_RST_CYCLES - 1);

    runner_state_t    rstate;
    logic [RST_W-1:0] rst_cnt;
    logic [1:0]       full;
    logic             run_bank;
    logic             run_pending;
    logic             frame_done;
    logic             done_bank;
    logic             load_reject;
    logic             run_req;
    logic             loader_busy;

    frame_loader #(
        .IMG_BYTES      (IMG_BYTES),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_loader (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .full        (full),
        .wr_en       (wr_en),
        .wr_bank     (wr_bank),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_done  (frame_done),
        .done_bank   (done_bank),
        .load_reject (load_reject),
        .run_req     (run_req),
        .err_timeout (err_timeout),
        .busy        (loader_busy)
    );

    assign busy = loader_busy || (rstate != R_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate       <= R_IDLE;
            rst_cnt      <= '0;
            full         <= 2'b00;
            run_bank     <= 1'b0;
            run_pending  <= 1'b0;
            cnn_rst      <= 1'b1;
            cnn_bank     <= 1'b0;
            lcd_bank     <= 1'b0;
            result       <= 4'd0;
            result_valid <= 1'b0;
            err_cmd      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            err_cmd      <= load_reject || (run_req && (full == 2'b00));

            if (frame_done) begin
                full[done_bank] <= 1'b1;
                lcd_bank        <= done_bank;
            end
            if ((run_req && (full != 2'b00)) || ((AUTO_RUN != 0) && frame_done))
                run_pending <= 1'b1;

            // Later assignments below win: a consumed request beats a repeat one.
            case (rstate)
                R_IDLE: begin
                    if (run_pending && full[run_bank]) begin
                        rstate      <= R_START;
                        run_pending <= 1'b0;
                        cnn_bank    <= run_bank;
                        rst_cnt     <= '0;
                    end
                end
                R_START: begin
                    if (rst_cnt == RST_LAST) begin
                        rstate  <= R_WAIT;
                        cnn_rst <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                R_WAIT: begin
                    if (cnn_finish) rstate <= R_DONE;
                end
                R_DONE: begin
                    // fill and run banks alternate, so this clear never hits the bank set above.
                    result         <= cnn_result;
                    result_valid   <= 1'b1;
                    full[run_bank] <= 1'b0;
                    run_bank       <= ~run_bank;
                    cnn_rst        <= 1'b1;
                    rstate         <= R_IDLE;
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_bank_scheduler.sv
// Directed bench for image_bank_scheduler with a behavioural CNN model.
module tb_image_bank_scheduler;

    localparam int IMG = 784;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       wr_en;
    logic       wr_bank;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       cnn_rst;
    logic       cnn_bank;
    logic       cnn_finish;
    logic [3:0] cnn_result;
    logic       lcd_bank;
    logic [3:0] result;
    logic       result_valid;
    logic       busy;
    logic       err_timeout;
    logic       err_cmd;

    int checks   = 0;
    int failures = 0;

    image_bank_scheduler #(
        .IMG_BYTES      (IMG),
        .ADDR_W         (10),
        .TIMEOUT_CYCLES (1000),
        .CNN_RST_CYCLES (2),
        .AUTO_RUN       (0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .wr_en        (wr_en),
        .wr_bank      (wr_bank),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cnn_rst      (cnn_rst),
        .cnn_bank     (cnn_bank),
        .cnn_finish   (cnn_finish),
        .cnn_result   (cnn_result),
        .lcd_bank     (lcd_bank),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_cmd      (err_cmd)
    );

    always #5 clk = ~clk;

    // CNN model: raises finish model_delay cycles after cnn_rst falls, holds until cnn_rst.
    int         model_delay  = 100;
    logic [3:0] model_result = 4'd7;
    int         model_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnn_finish <= 1'b0;
            cnn_result <= 4'd0;
            model_cnt  <= 0;
        end else if (cnn_rst) begin
            cnn_finish <= 1'b0;
            model_cnt  <= 0;
        end else if (!cnn_finish) begin
            if (model_cnt >= model_delay - 1) begin
                cnn_finish <= 1'b1;
                cnn_result <= model_result;
            end else begin
                model_cnt <= model_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the byte's effect visible.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cnn_rst"}, cnn_rst, 1);
        check({tag, "_wr"}, {wr_en, wr_bank, wr_addr, wr_data}, 0);
        check({tag, "_banks"}, {cnn_bank, lcd_bank}, 0);
        check({tag, "_result"}, {result, result_valid}, 0);
        check({tag, "_flags"}, {busy, err_timeout, err_cmd}, 0);
    endtask

    task automatic load_frame(input logic bank, input string tag);
        send_byte(8'h67);
        check({tag, "_g_nowrite"}, wr_en, 0);
        for (int i = 0; i < IMG; i++) begin
            send_byte(i[7:0]);
            check({tag, "_wr"}, {wr_en, wr_bank, wr_addr, wr_data},
                  {1'b1, bank, i[9:0], i[7:0]});
        end
        check({tag, "_lcd"}, lcd_bank, bank);
    endtask

    // Sends 'd' and returns once the CNN is released (R_WAIT).
    task automatic start_run(input logic bank, input string tag);
        int n = 0;
        int g = 0;
        send_byte(8'h64);
        check({tag, "_d_noerr"}, err_cmd, 0);
        while (cnn_rst && g < 50) begin
            if (busy) n++;
            @(negedge clk);
            g++;
        end
        check({tag, "_rst_cycles"}, n, 2);
        check({tag, "_cnn_bank"}, cnn_bank, bank);
    endtask

    // Waits for result_valid, checks the result and that the strobe lasts one cycle.
    task automatic finish_run(input logic [3:0] exp_res, input string tag);
        int g = 0;
        while (!result_valid && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_valid_seen"}, result_valid, 1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_cnn_rst_back"}, cnn_rst, 1);
        @(negedge clk);
        check({tag, "_valid_pulse"}, result_valid, 0);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       exp_err_cmd;
        logic       exp_wr_en;
        logic       exp_busy;
        logic       exp_cnn_rst;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Idle-state byte responses with both banks empty.
        vecs[0] = '{8'h78, 1'b0, 1'b0, 1'b0, 1'b1};  // 'x' ignored
        vecs[1] = '{8'h64, 1'b1, 1'b0, 1'b0, 1'b1};  // 'd' with no full bank
        vecs[2] = '{8'h61, 1'b0, 1'b0, 1'b0, 1'b1};  // 'a' ignored
        vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h64, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'hff, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            send_byte(vecs[i].b);
            check($sformatf("vec%0d", i), {err_cmd, wr_en, busy, cnn_rst},
                  {vecs[i].exp_err_cmd, vecs[i].exp_wr_en, vecs[i].exp_busy, vecs[i].exp_cnn_rst});
        end

        // Full frame into bank 0, then a stray byte must not write.
        load_frame(1'b0, "load0");
        send_byte(8'h78);
        check("post_frame_x", {wr_en, busy, err_cmd}, 0);

        // Single run on bank 0.
        model_delay  = 100;
        model_result = 4'd7;
        start_run(1'b0, "run0");
        finish_run(4'd7, "run0");
        check("run0_idle", busy, 0);
        send_byte(8'h64);
        check("run0_bank_freed", err_cmd, 1);

        // Reset while the CNN is running on bank 1.
        load_frame(1'b1, "load1");
        start_run(1'b1, "run1");
        repeat (10) @(negedge clk);
        check("run1_in_wait", cnn_rst, 0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h64);
        check("rst_full_cleared", {err_cmd, cnn_rst}, 2'b11);

        // Ping-pong: second run queued while the first is in R_WAIT.
        model_delay  = 2000;
        model_result = 4'd3;
        load_frame(1'b0, "pp_load0");
        start_run(1'b0, "pp_run0");
        load_frame(1'b1, "pp_load1");
        check("pp_still_waiting", cnn_rst, 0);
        send_byte(8'h64);
        check("pp_d_queued", err_cmd, 0);
        finish_run(4'd3, "pp_run0");
        model_result = 4'd9;
        check("pp_second_start", {cnn_bank, cnn_rst, busy}, 3'b111);
        n = 0;
        while (cnn_rst && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("pp_second_rst_cycles", n, 2);
        finish_run(4'd9, "pp_run1");
        check("pp_lcd", lcd_bank, 1);
        model_delay = 100;

        // Partial frame followed by silence.
        send_byte(8'h67);
        for (int i = 0; i < 100; i++) send_byte(i[7:0]);
        check("to_last_addr", {wr_en, wr_bank, wr_addr}, {1'b1, 1'b0, 10'd99});
        n = 0;
        while (!err_timeout && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check("to_seen", err_timeout, 1);
        check("to_latency_in_range", (n >= 1000 && n <= 1002), 1);
        check("to_busy", busy, 0);
        @(negedge clk);
        check("to_pulse", err_timeout, 0);
        send_byte(8'h64);
        check("to_full_unchanged", err_cmd, 1);
        load_frame(1'b0, "to_reload0");

        // Both banks full: a further 'g' is rejected.
        load_frame(1'b1, "fill1");
        send_byte(8'h67);
        check("both_full_g", {err_cmd, wr_en, busy, cnn_rst}, 4'b1001);
        @(negedge clk);
        check("both_full_nowrite", {wr_en, err_cmd}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
